if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 60 ++++++
 rtl/if_id_fields.sv | 26 ++
 rtl/if_id_buffer.sv | 108 ++++++++++
 3 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the fetch/decode boundary: buffer state encoding, instruction field
// positions and opcode constants.
package if_id_buffer_pkg;

   localparam int unsigned InstrW  = 16;
   localparam int unsigned OpcodeW = 3;
   localparam int unsigned RegW    = 3;
   localparam int unsigned Imm7W   = 7;
   localparam int unsigned Imm10W  = 10;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } buf_state_e;

   // Field bit positions within a 16-bit instruction word
   localparam int unsigned OpcodeHi = 15;
   localparam int unsigned OpcodeLo = 13;
   localparam int unsigned RegAHi   = 12;
   localparam int unsigned RegALo   = 10;
   localparam int unsigned RegBHi   = 9;
   localparam int unsigned RegBLo   = 7;
   localparam int unsigned RegCHi   = 2;
   localparam int unsigned RegCLo   = 0;
   localparam int unsigned Imm7Hi   = 6;
   localparam int unsigned Imm7Lo   = 0;
   localparam int unsigned Imm10Hi  = 9;
   localparam int unsigned Imm10Lo  = 0;

   localparam logic [OpcodeW-1:0] OpAdd  = 3'd0;
   localparam logic [OpcodeW-1:0] OpAddi = 3'd1;
   localparam logic [OpcodeW-1:0] OpNand = 3'd2;
   localparam logic [OpcodeW-1:0] OpLui  = 3'd3;
   localparam logic [OpcodeW-1:0] OpSw   = 3'd4;
   localparam logic [OpcodeW-1:0] OpLw   = 3'd5;
   localparam logic [OpcodeW-1:0] OpBeq  = 3'd6;
   localparam logic [OpcodeW-1:0] OpJalr = 3'd7;

   typedef struct packed {
      logic [OpcodeW-1:0] opcode;
      logic [RegW-1:0]    reg_a;
      logic [RegW-1:0]    reg_b;
      logic [RegW-1:0]    reg_c;
      logic [Imm7W-1:0]   imm7;
      logic [Imm10W-1:0]  imm10;
   } instr_fields_t;

   function automatic instr_fields_t slice_instr(input logic [InstrW-1:0] w);
      instr_fields_t f;
      f.opcode = w[OpcodeHi:OpcodeLo];
      f.reg_a  = w[RegAHi:RegALo];
      f.reg_b  = w[RegBHi:RegBLo];
      f.reg_c  = w[RegCHi:RegCLo];
      f.imm7   = w[Imm7Hi:Imm7Lo];
      f.imm10  = w[Imm10Hi:Imm10Lo];
      return f;
   endfunction

endpackage

// File: rtl/if_id_fields.sv
// Purely combinational split of a 16-bit instruction into opcode, register and raw immediates.
module if_id_fields
   import if_id_buffer_pkg::*;
(
   input  logic [InstrW-1:0]  instr_i,
   output logic [OpcodeW-1:0] opcode_o,
   output logic [RegW-1:0]    reg_a_o,
   output logic [RegW-1:0]    reg_b_o,
   output logic [RegW-1:0]    reg_c_o,
   output logic [Imm7W-1:0]   imm7_o,
   output logic [Imm10W-1:0]  imm10_o
);

   instr_fields_t fields;

   always_comb begin
      fields   = slice_instr(instr_i);
      opcode_o = fields.opcode;
      reg_a_o  = fields.reg_a;
      reg_b_o  = fields.reg_b;
      reg_c_o  = fields.reg_c;
      imm7_o   = fields.imm7;
      imm10_o  = fields.imm10;
   end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode; outputs come only from the registered head.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned PC_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2:0]         out_opcode,
   output logic [2:0]         out_reg_a,
   output logic [2:0]         out_reg_b,
   output logic [2:0]         out_reg_c,
   output logic [6:0]         out_imm7,
   output logic [9:0]         out_imm10,
   output logic [PC_W-1:0]    out_pc
);

   buf_state_e         state_q, state_d;
   logic [INSTR_W-1:0] head_instr_q, head_instr_d;
   logic [PC_W-1:0]    head_pc_q, head_pc_d;
   logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
   logic [PC_W-1:0]    tail_pc_q, tail_pc_d;
   logic               accept, consume;

   assign in_ready  = (state_q != StFull) & ~rst;
   assign out_valid = (state_q != StEmpty);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;
      tail_instr_d = tail_instr_q;
      tail_pc_d    = tail_pc_q;
      if (flush) begin
         // Payload is left untouched so out_* keep their last values while empty
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  head_instr_d = in_instr;
                  head_pc_d    = in_pc;
                  state_d      = StOne;
               end
            end
            StOne: begin
               if (accept && !consume) begin
                  tail_instr_d = in_instr;
                  tail_pc_d    = in_pc;
                  state_d      = StFull;
               end else if (consume && !accept) begin
                  state_d = StEmpty;
               end else if (accept && consume) begin
                  head_instr_d = in_instr;
                  head_pc_d    = in_pc;
               end
            end
            StFull: begin
               if (consume) begin
                  head_instr_d = tail_instr_q;
                  head_pc_d    = tail_pc_q;
                  state_d      = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StEmpty;
         head_instr_q <= '0;
         head_pc_q    <= '0;
         tail_instr_q <= '0;
         tail_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         head_instr_q <= head_instr_d;
         head_pc_q    <= head_pc_d;
         tail_instr_q <= tail_instr_d;
         tail_pc_q    <= tail_pc_d;
      end
   end

   if_id_fields u_fields (
      .instr_i  (head_instr_q),
      .opcode_o (out_opcode),
      .reg_a_o  (out_reg_a),
      .reg_b_o  (out_reg_b),
      .reg_c_o  (out_reg_c),
      .imm7_o   (out_imm7),
      .imm10_o  (out_imm10)
   );

   assign out_pc = head_pc_q;

endmodule
